serial_cmp_scheduler: RTL and testbench

//  Shares one bit-serial magnitude comparator (shift-register pair plus L/E/G FSM) among N requesters.

---
 rtl/serial_cmp_scheduler_pkg.sv | 24 ++
 rtl/serial_cmp_scheduler_arb.sv | 33 +++
 rtl/serial_cmp_scheduler.sv | 162 ++++++++++++++++
 tb/tb_serial_cmp_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_cmp_scheduler_pkg.sv
// Shared definitions for the serial comparator scheduler: FSM state
// encodings, the requester-index width and a small round-robin helper.
package serial_cmp_scheduler_pkg;

    localparam int SCMP_IDW = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_RESULT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Advance a requester index by one, wrapping back to zero after n-1.
    function automatic logic [SCMP_IDW-1:0] wrapInc(input logic [SCMP_IDW-1:0] idx,
                                                    input int n);
        if (int'(idx) >= n - 1) begin
            return '0;
        end
        return idx + SCMP_IDW'(1);
    endfunction

endpackage

// File: rtl/serial_cmp_scheduler_arb.sv
// Round-robin arbiter: grants the first active request found at or after
// the pointer position, wrapping around. Purely combinational.
module rr_arbiter
    import serial_cmp_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req_i,
    input  logic [SCMP_IDW-1:0]   ptr_i,
    output logic [N-1:0]          gnt_o,
    output logic [SCMP_IDW-1:0]   idx_o
);

    int   pos;
    logic found;

    // Scan requesters starting at the pointer; the first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr_i) + i) % N;
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = SCMP_IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/serial_cmp_scheduler.sv
// Shares one external bit-serial magnitude comparator among N requesters.
// A round-robin arbiter picks a winner in IDLE, then the FSM loads the
// comparator, shifts W cycles, strobes the result and returns it with a
// one-cycle done/ack pulse.
// Optional build macro: SERIAL_CMP_SCHED_CHECK_EN enables a sticky error
// flag raised when the comparator's L/E/G result is not one-hot.
module serial_cmp_scheduler
    import serial_cmp_scheduler_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*W-1:0]      a_in,
    input  logic [N*W-1:0]      b_in,
    output logic [N-1:0]        ack,
    output logic                done,
    output logic                res_lt,
    output logic                res_eq,
    output logic                res_gt,
    output logic [SCMP_IDW-1:0] res_id,
    output logic                busy,
    output logic                err,
    output logic                cmp_rst,
    output logic                cmp_mode,
    output logic                cmp_op,
    output logic [W-1:0]        cmp_a,
    output logic [W-1:0]        cmp_b,
    input  logic                cmp_l,
    input  logic                cmp_e,
    input  logic                cmp_g
);

    localparam int CNT_W = $clog2(W) + 1;

    state_t                state_q;
    state_t                state_d;
    logic [SCMP_IDW-1:0]   sel_q;
    logic [SCMP_IDW-1:0]   rrPtr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  resLt_q;
    logic                  resEq_q;
    logic                  resGt_q;
    logic [SCMP_IDW-1:0]   resId_q;
    logic [N-1:0]          arbGnt;
    logic [SCMP_IDW-1:0]   arbIdx;
    logic                  anyReq;

    rr_arbiter #(.N(N)) u_arb (
        .req_i (req),
        .ptr_i (rrPtr_q),
        .gnt_o (arbGnt),
        .idx_o (arbIdx)
    );

    assign anyReq = |arbGnt;

    // The winner's operands stay on the comparator bus in every state;
    // the comparator only captures them during LOAD.
    assign cmp_a = a_in[int'(sel_q)*W +: W];
    assign cmp_b = b_in[int'(sel_q)*W +: W];

    assign res_lt = resLt_q;
    assign res_eq = resEq_q;
    assign res_gt = resGt_q;
    assign res_id = resId_q;

    // State register; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing: arbitrate, load, shift W times, strobe, report.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (anyReq) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_SHIFT;
            ST_SHIFT:  if (cnt_q == '0) state_d = ST_RESULT;
            ST_RESULT: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Comparator controls and requester handshakes decoded from the state.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = 1'b0;
        ack      = '0;
        cmp_rst  = rst;
        cmp_mode = 1'b0;
        cmp_op   = 1'b0;
        case (state_q)
            ST_LOAD: begin
                cmp_rst  = 1'b1;
                cmp_mode = 1'b1;
            end
            ST_RESULT: cmp_op = 1'b1;
            ST_DONE: begin
                done       = 1'b1;
                ack[sel_q] = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: winner latch, shift counter, result capture and pointer advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= '0;
            rrPtr_q <= '0;
            cnt_q   <= '0;
            resLt_q <= 1'b0;
            resEq_q <= 1'b0;
            resGt_q <= 1'b0;
            resId_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (anyReq) sel_q <= arbIdx;
                end
                ST_LOAD: cnt_q <= CNT_W'(W - 1);
                ST_SHIFT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                ST_RESULT: begin
                    resLt_q <= cmp_l;
                    resEq_q <= cmp_e;
                    resGt_q <= cmp_g;
                    resId_q <= sel_q;
                end
                ST_DONE: rrPtr_q <= wrapInc(sel_q, N);
                default: ;
            endcase
        end
    end

`ifdef SERIAL_CMP_SCHED_CHECK_EN
    logic err_q;

    // Sticky flag for a comparator result that is not exactly one-hot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == ST_RESULT && !$onehot({cmp_l, cmp_e, cmp_g})) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmp_scheduler.sv
// Self-checking bench for serial_cmp_scheduler (N=4, W=32) with a
// behavioural bit-serial comparator and a scoreboard-driven monitor.
module tb_serial_cmp_scheduler;

    localparam int N = 4;
    localparam int W = 32;
`ifdef SERIAL_CMP_SCHED_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct {
        int   id;
        logic lt;
        logic eq;
        logic gt;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in;
    logic [N*W-1:0] b_in;
    logic [N-1:0]   ack;
    logic           done;
    logic           res_lt, res_eq, res_gt;
    logic [2:0]     res_id;
    logic           busy, err;
    logic           cmp_rst, cmp_mode, cmp_op;
    logic [W-1:0]   cmp_a, cmp_b;
    logic           cmp_l, cmp_e, cmp_g;

    int   total = 0;
    int   bad = 0;
    int   cycleCnt = 0;
    exp_t expQ[$];
    exp_t mon;
    logic forceBad = 1'b0;

    logic [W-1:0] sa, sb;
    int           mst;

    serial_cmp_scheduler #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .ack      (ack),
        .done     (done),
        .res_lt   (res_lt),
        .res_eq   (res_eq),
        .res_gt   (res_gt),
        .res_id   (res_id),
        .busy     (busy),
        .err      (err),
        .cmp_rst  (cmp_rst),
        .cmp_mode (cmp_mode),
        .cmp_op   (cmp_op),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .cmp_l    (cmp_l),
        .cmp_e    (cmp_e),
        .cmp_g    (cmp_g)
    );

    always #5 clk = ~clk;

    // Cycle index used for latency measurements.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural bit-serial comparator: MSB-first, first differing bit decides.
    always @(posedge clk) begin
        if (cmp_rst) begin
            mst <= 0;
            if (cmp_mode) begin
                sa <= cmp_a;
                sb <= cmp_b;
            end
        end else if (!cmp_mode) begin
            sa <= sa << 1;
            sb <= sb << 1;
            if (mst == 0 && sa[W-1] != sb[W-1]) mst <= sa[W-1] ? 2 : 1;
        end
    end

    assign cmp_l = (forceBad && cmp_op) ? 1'b1 : (mst == 1);
    assign cmp_e = (forceBad && cmp_op) ? 1'b0 : (mst == 0);
    assign cmp_g = (forceBad && cmp_op) ? 1'b1 : (mst == 2);

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            checkOutput("done_expected", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                mon = expQ.pop_front();
                checkOutput("ack", 32'(ack), 32'(1 << mon.id));
                checkOutput("res_id", 32'(res_id), 32'(mon.id));
                checkOutput("res_lt", 32'(res_lt), 32'(mon.lt));
                checkOutput("res_eq", 32'(res_eq), 32'(mon.eq));
                checkOutput("res_gt", 32'(res_gt), 32'(mon.gt));
            end
        end
    end

    task automatic waitDone(output int doneAt);
        doneAt = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                doneAt = cycleCnt;
                break;
            end
        end
        if (doneAt < 0) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    // One single-requester job with a latency check from the IDLE sample cycle.
    task automatic applyStimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic lt, input logic eq, input logic gt);
        int startCycle;
        int doneAt;
        a_in[id*W +: W] = a;
        b_in[id*W +: W] = b;
        expQ.push_back('{id: id, lt: lt, eq: eq, gt: gt});
        startCycle = cycleCnt;
        req[id] = 1'b1;
        waitDone(doneAt);
        checkOutput("latency", 32'(doneAt - startCycle), 32'(W + 3));
        @(posedge clk);
        #1 req[id] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int t0, t1, t2, t3;
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("rst_res", 32'({res_lt, res_eq, res_gt}), 0);
        checkOutput("rst_res_id", 32'(res_id), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_cmp_rst", 32'(cmp_rst), 1);
        checkOutput("rst_cmp_mode", 32'(cmp_mode), 0);
        checkOutput("rst_cmp_op", 32'(cmp_op), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_cmp_rst", 32'(cmp_rst), 0);
        @(posedge clk);
        #1;

        $display("[TB] basic compares");
        applyStimulus(0, 32'd5, 32'd9, 1'b1, 1'b0, 1'b0);
        applyStimulus(2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        applyStimulus(2, 32'h80000000, 32'd1, 1'b0, 1'b0, 1'b1);
        applyStimulus(3, 32'd3, 32'd2, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 32'd2, 32'd3, 1'b1, 1'b0, 1'b0);

        $display("[TB] reset mid-job");
        a_in[2*W +: W] = 32'd100;
        b_in[2*W +: W] = 32'd7;
        req[2] = 1'b1;
        repeat (23) @(posedge clk);
        #1;
        checkOutput("busy_mid_job", 32'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_ack", 32'(ack), 0);
        checkOutput("abort_res_cleared", 32'({res_lt, res_eq, res_gt}), 0);
        req = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] round robin from pointer zero");
        a_in[0*W +: W] = 32'd1;  b_in[0*W +: W] = 32'd2;
        a_in[1*W +: W] = 32'd7;  b_in[1*W +: W] = 32'd7;
        a_in[3*W +: W] = 32'd9;  b_in[3*W +: W] = 32'd4;
        expQ.push_back('{id: 0, lt: 1'b1, eq: 1'b0, gt: 1'b0});
        expQ.push_back('{id: 1, lt: 1'b0, eq: 1'b1, gt: 1'b0});
        expQ.push_back('{id: 3, lt: 1'b0, eq: 1'b0, gt: 1'b1});
        expQ.push_back('{id: 0, lt: 1'b1, eq: 1'b0, gt: 1'b0});
        req = 4'b1011;
        waitDone(t0);
        waitDone(t1);
        waitDone(t2);
        waitDone(t3);
        @(posedge clk);
        #1 req = '0;
        checkOutput("rr_gap_01", 32'(t1 - t0), 32'(W + 4));
        checkOutput("rr_gap_13", 32'(t2 - t1), 32'(W + 4));
        checkOutput("rr_gap_30", 32'(t3 - t2), 32'(W + 4));
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rr_idle_after", 32'(busy), 0);
        @(posedge clk);
        #1;

        $display("[TB] comparator result check");
        forceBad = 1'b1;
        applyStimulus(0, 32'd4, 32'd4, 1'b1, 1'b0, 1'b1);
        forceBad = 1'b0;
        checkOutput("err_after_bad", 32'(err), 32'(ERR_EXP));
        applyStimulus(1, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0);
        checkOutput("err_sticky", 32'(err), 32'(ERR_EXP));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("err_cleared", 32'(err), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        checkOutput("queue_empty", 32'(expQ.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
